// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer: state encoding, BCD digit width and time payload.
package timer_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned BCD_W   = 4;

  localparam logic [BCD_W-1:0] BCD_ZERO = BCD_W'(0);
  localparam logic [BCD_W-1:0] BCD_ONE  = BCD_W'(1);
  localparam logic [BCD_W-1:0] BCD_FIVE = BCD_W'(5);
  localparam logic [BCD_W-1:0] BCD_NINE = BCD_W'(9);

  typedef enum logic [STATE_W-1:0] {
    SETTING = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    BEEPING = 2'd3
  } state_e;

  // mm:ss as four BCD digits, most significant first
  typedef struct packed {
    logic [BCD_W-1:0] tm;
    logic [BCD_W-1:0] m;
    logic [BCD_W-1:0] ts;
    logic [BCD_W-1:0] s;
  } bcd_time_t;

endpackage

// File: rtl/countdown_timer_core_if.sv
// Button pulses in, BCD display / status out, between the debouncers and the display/alarm blocks.
interface countdown_timer_core_if;
  import timer_pkg::*;

  logic               up_p;
  logic               dn_p;
  logic               cancel_p;
  logic               start_stop_p;
  logic [BCD_W-1:0]   secs;
  logic [BCD_W-1:0]   ten_secs;
  logic [BCD_W-1:0]   mins;
  logic [BCD_W-1:0]   ten_mins;
  logic [STATE_W-1:0] state_o;
  logic               alarm_on;
  logic               tick_o;

  modport master (
    output up_p, dn_p, cancel_p, start_stop_p,
    input  secs, ten_secs, mins, ten_mins, state_o, alarm_on, tick_o
  );

  modport slave (
    input  up_p, dn_p, cancel_p, start_stop_p,
    output secs, ten_secs, mins, ten_mins, state_o, alarm_on, tick_o
  );

endinterface

// File: rtl/tick_prescaler.sv
// One-second prescaler: counts 0..TICK_DIV-1 while enabled, holds otherwise; sync clear has priority.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 12000000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_c_o
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Tick is combinational so the owning FSM can act on the wrap edge itself
  assign tick_c_o = en_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/countdown_timer_core.sv
// Kitchen-timer controller: BCD mm:ss countdown with set/run/pause/alarm states.
// Define TIMER_AUTORELOAD_EN to restart the countdown from BEEPING instead of returning to SETTING.
module countdown_timer_core
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 12000000,
  parameter int unsigned MAX_MINS   = 99,
  parameter int unsigned DEF_MINS   = 1,
  parameter int unsigned ALARM_SECS = 30
) (
  input logic                   CLK,
  input logic                   RST_N,
  countdown_timer_core_if.slave bus
);

  localparam int unsigned ACNT_W = (ALARM_SECS > 2) ? $clog2(ALARM_SECS) : 1;
  localparam logic [BCD_W-1:0] MAX_TM = BCD_W'(MAX_MINS / 10);
  localparam logic [BCD_W-1:0] MAX_M  = BCD_W'(MAX_MINS % 10);
  localparam logic [BCD_W-1:0] DEF_TM = BCD_W'(DEF_MINS / 10);
  localparam logic [BCD_W-1:0] DEF_M  = BCD_W'(DEF_MINS % 10);

  state_e              state_q, state_d;
  bcd_time_t           time_q, time_d;
  logic [2*BCD_W-1:0]  stored_q, stored_d;
  logic                alarm_q, alarm_d;
  logic                tick_q, tick_d;
  logic [ACNT_W-1:0]   acnt_q, acnt_d;

  logic                pre_en_c, pre_clr_c, tick_c, final_c, timeout_c;
  bcd_time_t           dec_c, reload_c;
  logic [2*BCD_W-1:0]  inc_min_c, dec_min_c;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .en_i     (pre_en_c),
    .clr_i    (pre_clr_c),
    .tick_c_o (tick_c)
  );

  assign pre_en_c  = (state_q == RUNNING) || (state_q == BEEPING);
  assign reload_c  = {stored_q, BCD_ZERO, BCD_ZERO};
  assign timeout_c = (ALARM_SECS != 0) && tick_c && (acnt_q == ACNT_W'(ALARM_SECS - 1));

  // One-second BCD borrow chain
  always_comb begin
    dec_c = time_q;
    if (time_q.s != BCD_ZERO) begin
      dec_c.s = time_q.s - BCD_ONE;
    end else begin
      dec_c.s = BCD_NINE;
      if (time_q.ts != BCD_ZERO) begin
        dec_c.ts = time_q.ts - BCD_ONE;
      end else begin
        dec_c.ts = BCD_FIVE;
        if (time_q.m != BCD_ZERO) begin
          dec_c.m = time_q.m - BCD_ONE;
        end else begin
          dec_c.m  = BCD_NINE;
          dec_c.tm = time_q.tm - BCD_ONE;
        end
      end
    end
    final_c = (dec_c == '0);
  end

  // Minute setting with wrap between 1 and MAX_MINS, kept in BCD throughout
  always_comb begin
    inc_min_c = {time_q.tm, time_q.m};
    dec_min_c = {time_q.tm, time_q.m};
    if ({time_q.tm, time_q.m} == {MAX_TM, MAX_M}) inc_min_c = {BCD_ZERO, BCD_ONE};
    else if (time_q.m == BCD_NINE)                inc_min_c = {time_q.tm + BCD_ONE, BCD_ZERO};
    else                                          inc_min_c = {time_q.tm, time_q.m + BCD_ONE};
    if ({time_q.tm, time_q.m} == {BCD_ZERO, BCD_ONE}) dec_min_c = {MAX_TM, MAX_M};
    else if (time_q.m == BCD_ZERO)                    dec_min_c = {time_q.tm - BCD_ONE, BCD_NINE};
    else                                              dec_min_c = {time_q.tm, time_q.m - BCD_ONE};
  end

  always_comb begin
    state_d   = state_q;
    time_d    = time_q;
    stored_d  = stored_q;
    alarm_d   = alarm_q;
    acnt_d    = acnt_q;
    tick_d    = 1'b0;
    pre_clr_c = 1'b0;
    unique case (state_q)
      SETTING: begin
        if (bus.start_stop_p) begin
          stored_d  = {time_q.tm, time_q.m};
          pre_clr_c = 1'b1;
          state_d   = RUNNING;
        end else if (bus.up_p && !bus.dn_p) begin
          time_d = {inc_min_c, BCD_ZERO, BCD_ZERO};
        end else if (bus.dn_p && !bus.up_p) begin
          time_d = {dec_min_c, BCD_ZERO, BCD_ZERO};
        end
      end
      RUNNING: begin
        tick_d = tick_c;
        // The tick reaching 00:00 outranks any coincident button
        if (tick_c && final_c) begin
          time_d    = '0;
          alarm_d   = 1'b1;
          acnt_d    = '0;
          pre_clr_c = 1'b1;
          state_d   = BEEPING;
        end else if (bus.cancel_p) begin
          time_d  = reload_c;
          state_d = SETTING;
        end else begin
          if (tick_c)            time_d  = dec_c;
          if (bus.start_stop_p)  state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (bus.cancel_p) begin
          time_d  = reload_c;
          state_d = SETTING;
        end else if (bus.start_stop_p) begin
          state_d = RUNNING;
        end
      end
      BEEPING: begin
        if (tick_c) acnt_d = acnt_q + ACNT_W'(1);
        if (bus.cancel_p) begin
          time_d  = reload_c;
          alarm_d = 1'b0;
          acnt_d  = '0;
          state_d = SETTING;
        end else if (bus.start_stop_p || timeout_c) begin
          time_d  = reload_c;
          alarm_d = 1'b0;
          acnt_d  = '0;
`ifdef TIMER_AUTORELOAD_EN
          pre_clr_c = 1'b1;
          state_d   = RUNNING;
`else
          state_d   = SETTING;
`endif
        end
      end
      default: state_d = SETTING;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= SETTING;
      time_q   <= {DEF_TM, DEF_M, BCD_ZERO, BCD_ZERO};
      stored_q <= {DEF_TM, DEF_M};
      alarm_q  <= 1'b0;
      tick_q   <= 1'b0;
      acnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      stored_q <= stored_d;
      alarm_q  <= alarm_d;
      tick_q   <= tick_d;
      acnt_q   <= acnt_d;
    end
  end

  assign bus.secs     = time_q.s;
  assign bus.ten_secs = time_q.ts;
  assign bus.mins     = time_q.m;
  assign bus.ten_mins = time_q.tm;
  assign bus.state_o  = state_q;
  assign bus.alarm_on = alarm_q;
  assign bus.tick_o   = tick_q;

endmodule
